// File: rtl/sti_rx_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sti_rx_if : serial-in / parallel-out handshake bundle for sti_rx    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface sti_rx_if;
    logic        si_data;
    logic        si_valid;
    logic [15:0] po_data;
    logic        po_valid;
    logic        po_ready;

    modport master (
        output si_data, si_valid, po_ready,
        input  po_data, po_valid
    );

    modport slave (
        input  si_data, si_valid, po_ready,
        output po_data, po_valid
    );
endinterface
`default_nettype wire

// File: rtl/sti_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sti_rx : STI serial frame receiver with one-entry output buffer.    |
// | Option macro STI_RX_PAD_CHECK_EN enables the pad-bit checker.       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module sti_rx (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       cfg_load,
    input  wire logic [1:0] cfg_length,
    input  wire logic       cfg_msb,
    input  wire logic       cfg_low,
    input  wire logic       cfg_fill,
    input  wire logic       rx_end,
    sti_rx_if.slave         bus,
    output logic            frame_err,
    output logic            overrun,
    output logic            pad_err,
    output logic            rx_done,
    output logic [8:0]      frame_cnt
);

    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DONE = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [1:0]  len_q, len_d;
    logic        msb_q, msb_d, low_q, low_d, fill_q, fill_d;
    logic [31:0] w_q, w_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        rx_done_q, rx_done_d;
    logic [8:0]  fcnt_q, fcnt_d;

    logic        use_new;
    logic [4:0]  nm1, pos;
    logic [31:0] w_next;
    logic [15:0] word;
    logic        complete, load;
`ifdef STI_RX_PAD_CHECK_EN
    logic        pad_err_q, pad_err_d;
    logic [15:0] pad_bits;
`endif

    always_comb begin
        // A frame starting on the same cycle as cfg_load uses the new settings.
        use_new  = (state_q == IDLE) && cfg_load;
        len_d    = use_new ? cfg_length : len_q;
        msb_d    = use_new ? cfg_msb    : msb_q;
        low_d    = use_new ? cfg_low    : low_q;
        fill_d   = use_new ? cfg_fill   : fill_q;

        nm1      = {len_d, 3'b111};
        pos      = msb_d ? (nm1 - cnt_q) : cnt_q;
        w_next   = ((state_q == IDLE) ? 32'd0 : w_q) | (32'(bus.si_data) << pos);

        state_d     = state_q;
        w_d         = w_q;
        cnt_d       = cnt_q;
        complete    = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_end) begin
                    state_d = DONE;
                end else if (bus.si_valid) begin
                    w_d     = w_next;
                    cnt_d   = 5'd1;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (bus.si_valid) begin
                    w_d = w_next;
                    if (cnt_q == nm1) begin
                        complete = 1'b1;
                        cnt_d    = 5'd0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end else begin
                    frame_err_d = 1'b1;
                    w_d         = 32'd0;
                    cnt_d       = 5'd0;
                    state_d     = IDLE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase

        case (len_d)
            2'b00:   word = low_d ? {w_next[7:0], 8'h00} : {8'h00, w_next[7:0]};
            2'b01:   word = w_next[15:0];
            2'b10:   word = fill_d ? w_next[23:8]  : w_next[15:0];
            default: word = fill_d ? w_next[31:16] : w_next[15:0];
        endcase

        load    = complete && (!valid_q || bus.po_ready);
        data_d  = load ? word : data_q;
        valid_d = load ? 1'b1 : (valid_q && !bus.po_ready);
        fcnt_d  = load ? fcnt_q + 9'd1 : fcnt_q;
        if (complete && !load) begin
            overrun_d = 1'b1;
        end
        rx_done_d = (state_d == DONE);

`ifdef STI_RX_PAD_CHECK_EN
        case (len_d)
            2'b10:   pad_bits = fill_d ? {8'h00, w_next[7:0]} : {8'h00, w_next[23:16]};
            2'b11:   pad_bits = fill_d ? w_next[15:0] : w_next[31:16];
            default: pad_bits = 16'h0000;
        endcase
        pad_err_d = load && (|pad_bits);
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            len_q       <= 2'b00;
            msb_q       <= 1'b0;
            low_q       <= 1'b0;
            fill_q      <= 1'b0;
            w_q         <= 32'd0;
            cnt_q       <= 5'd0;
            data_q      <= 16'h0000;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rx_done_q   <= 1'b0;
            fcnt_q      <= 9'd0;
`ifdef STI_RX_PAD_CHECK_EN
            pad_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            msb_q       <= msb_d;
            low_q       <= low_d;
            fill_q      <= fill_d;
            w_q         <= w_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            rx_done_q   <= rx_done_d;
            fcnt_q      <= fcnt_d;
`ifdef STI_RX_PAD_CHECK_EN
            pad_err_q   <= pad_err_d;
`endif
        end
    end

    assign bus.po_data  = data_q;
    assign bus.po_valid = valid_q;
    assign frame_err    = frame_err_q;
    assign overrun      = overrun_q;
    assign rx_done      = rx_done_q;
    assign frame_cnt    = fcnt_q;
`ifdef STI_RX_PAD_CHECK_EN
    assign pad_err      = pad_err_q;
`else
    assign pad_err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sti_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sti_rx : self-checking bench for sti_rx with a word-level model. |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_sti_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_load;
    logic [1:0] cfg_length;
    logic       cfg_msb, cfg_low, cfg_fill;
    logic       rx_end;
    logic       frame_err, overrun, pad_err, rx_done;
    logic [8:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    bit pad_on;

    sti_rx_if bus_if ();

    sti_rx dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_load   (cfg_load),
        .cfg_length (cfg_length),
        .cfg_msb    (cfg_msb),
        .cfg_low    (cfg_low),
        .cfg_fill   (cfg_fill),
        .rx_end     (rx_end),
        .bus        (bus_if.slave),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .pad_err    (pad_err),
        .rx_done    (rx_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: word extraction from the N-bit frame value.
    function automatic logic [15:0] model_word(int len, bit low, bit fill, logic [31:0] w);
        case (len)
            0:       return low ? 16'((w & 32'hFF) << 8) : 16'(w & 32'hFF);
            1:       return 16'(w & 32'hFFFF);
            2:       return fill ? 16'((w >> 8) & 32'hFFFF) : 16'(w & 32'hFFFF);
            default: return fill ? 16'(w >> 16) : 16'(w & 32'hFFFF);
        endcase
    endfunction

    function automatic bit model_pad_bad(int len, bit fill, logic [31:0] w);
        if (!pad_on) return 1'b0;
        case (len)
            2:       return fill ? ((w & 32'hFF) != 0) : (((w >> 16) & 32'hFF) != 0);
            3:       return fill ? ((w & 32'hFFFF) != 0) : ((w >> 16) != 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic do_cfg(input int len, input bit msb, input bit low, input bit fill);
        @(negedge clk);
        cfg_length = 2'(len);
        cfg_msb = msb; cfg_low = low; cfg_fill = fill;
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    // Drives the frame bits on consecutive cycles; si_valid is left high.
    task automatic send_frame(input int len, input bit msb, input logic [31:0] w);
        int n;
        n = 8 * (len + 1);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus_if.si_valid = 1'b1;
            bus_if.si_data  = msb ? w[n-1-k] : w[k];
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (bus_if.po_data !== 16'h0 || bus_if.po_valid !== 1'b0 || frame_err !== 1'b0 ||
            overrun !== 1'b0 || pad_err !== 1'b0 || rx_done !== 1'b0 || frame_cnt !== 9'd0) begin
            n_fail++;
            $display("FAIL reset: data=%h valid=%b ferr=%b ovr=%b pad=%b done=%b cnt=%0d, required all zero",
                     bus_if.po_data, bus_if.po_valid, frame_err, overrun, pad_err, rx_done, frame_cnt);
        end
    endtask

    task automatic test_frame_err();
        do_cfg(2, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus_if.si_valid = 1'b1;
            bus_if.si_data  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bus_if.si_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (frame_err !== 1'b1 || bus_if.po_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_err_pulse: ferr=%b valid=%b, required ferr=1 valid=0", frame_err, bus_if.po_valid);
        end
        @(negedge clk);
        n_checks++;
        if (frame_err !== 1'b0 || frame_cnt !== 9'(exp_cnt) || bus_if.po_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_err_after: ferr=%b cnt=%0d valid=%b, required 0/%0d/0",
                     frame_err, frame_cnt, bus_if.po_valid, exp_cnt);
        end
    endtask

    task automatic test_len16_msb();
        bus_if.po_ready = 1'b1;
        do_cfg(1, 1'b1, 1'b0, 1'b0);
        send_frame(1, 1'b1, 32'h0000_A5C3);
        n_checks++;
        if (bus_if.po_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL len16_early_valid: valid=%b, required 0", bus_if.po_valid);
        end
        @(negedge clk);
        bus_if.si_valid = 1'b0;
        exp_cnt++;
        n_checks++;
        if (bus_if.po_valid !== 1'b1 || bus_if.po_data !== 16'hA5C3 || frame_cnt !== 9'(exp_cnt)) begin
            n_fail++;
            $display("FAIL len16_word: valid=%b data=%h cnt=%0d, required 1/a5c3/%0d",
                     bus_if.po_valid, bus_if.po_data, frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_len8_low();
        for (int lo = 1; lo >= 0; lo--) begin
            do_cfg(0, 1'b0, 1'(lo), 1'b0);
            send_frame(0, 1'b0, 32'h3C);
            @(negedge clk);
            bus_if.si_valid = 1'b0;
            exp_cnt++;
            n_checks++;
            if (bus_if.po_valid !== 1'b1 || bus_if.po_data !== (lo != 0 ? 16'h3C00 : 16'h003C)) begin
                n_fail++;
                $display("FAIL len8_low%0d: valid=%b data=%h, required 1/%h",
                         lo, bus_if.po_valid, bus_if.po_data, (lo != 0 ? 16'h3C00 : 16'h003C));
            end
        end
    endtask

    task automatic test_len32_pad();
        logic [31:0] vals [2];
        vals[0] = 32'h1234_0000;
        vals[1] = 32'h1234_0001;
        do_cfg(3, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            send_frame(3, 1'b1, vals[i]);
            @(negedge clk);
            bus_if.si_valid = 1'b0;
            exp_cnt++;
            n_checks++;
            if (bus_if.po_data !== 16'h1234 || pad_err !== (i == 1 && pad_on)) begin
                n_fail++;
                $display("FAIL len32_pad%0d: data=%h pad=%b, required 1234/%b",
                         i, bus_if.po_data, pad_err, (i == 1 && pad_on));
            end
            @(negedge clk);
            n_checks++;
            if (pad_err !== 1'b0) begin
                n_fail++;
                $display("FAIL len32_pad_width%0d: pad=%b, required 0", i, pad_err);
            end
        end
    endtask

    task automatic test_overrun();
        do_cfg(0, 1'b0, 1'b0, 1'b0);
        bus_if.po_ready = 1'b0;
        send_frame(0, 1'b0, 32'h11);
        send_frame(0, 1'b0, 32'h22);
        @(negedge clk);
        bus_if.si_valid = 1'b0;
        exp_cnt++;
        n_checks++;
        if (overrun !== 1'b1 || bus_if.po_data !== 16'h0011 || bus_if.po_valid !== 1'b1 ||
            frame_cnt !== 9'(exp_cnt)) begin
            n_fail++;
            $display("FAIL overrun_pulse: ovr=%b data=%h valid=%b cnt=%0d, required 1/0011/1/%0d",
                     overrun, bus_if.po_data, bus_if.po_valid, frame_cnt, exp_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (overrun !== 1'b0 || bus_if.po_data !== 16'h0011) begin
            n_fail++;
            $display("FAIL overrun_once: ovr=%b data=%h, required 0/0011", overrun, bus_if.po_data);
        end
        bus_if.po_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus_if.po_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_handshake: valid=%b, required 0", bus_if.po_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] fr [3];
        fr[0] = 8'h5A; fr[1] = 8'hC3; fr[2] = 8'h7E;
        do_cfg(0, 1'b0, 1'b0, 1'b0);
        bus_if.po_ready = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i == 8) begin
                n_checks++;
                if (bus_if.po_valid !== 1'b1 || bus_if.po_data !== 16'h005A) begin
                    n_fail++;
                    $display("FAIL b2b_first: valid=%b data=%h, required 1/005a", bus_if.po_valid, bus_if.po_data);
                end
            end
            if (i == 15) bus_if.po_ready = 1'b1;
            if (i == 16) begin
                n_checks++;
                if (bus_if.po_valid !== 1'b1 || bus_if.po_data !== 16'h00C3 || overrun !== 1'b0 ||
                    frame_cnt !== 9'(exp_cnt + 2)) begin
                    n_fail++;
                    $display("FAIL b2b_same_edge: valid=%b data=%h ovr=%b cnt=%0d, required 1/00c3/0/%0d",
                             bus_if.po_valid, bus_if.po_data, overrun, frame_cnt, exp_cnt + 2);
                end
            end
            if (i == 17) begin
                n_checks++;
                if (bus_if.po_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_drain: valid=%b, required 0", bus_if.po_valid);
                end
            end
            bus_if.si_valid = 1'b1;
            bus_if.si_data  = fr[i/8][i%8];
        end
        @(negedge clk);
        bus_if.si_valid = 1'b0;
        exp_cnt += 3;
        n_checks++;
        if (bus_if.po_valid !== 1'b1 || bus_if.po_data !== 16'h007E || frame_cnt !== 9'(exp_cnt)) begin
            n_fail++;
            $display("FAIL b2b_third: valid=%b data=%h cnt=%0d, required 1/007e/%0d",
                     bus_if.po_valid, bus_if.po_data, frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_random();
        int len; bit msb, low, fill;
        logic [31:0] w;
        logic [15:0] exp_w;
        bit exp_pad;
        bus_if.po_ready = 1'b1;
        for (int t = 0; t < 24; t++) begin
            len  = int'($urandom_range(0, 3));
            msb  = 1'($urandom_range(0, 1));
            low  = 1'($urandom_range(0, 1));
            fill = 1'($urandom_range(0, 1));
            w    = $urandom;
            if (len < 3) w = w & ((32'd1 << (8 * (len + 1))) - 1);
            if ($urandom_range(0, 2) == 0) w = w & 32'hFF00_FF00;
            exp_w   = model_word(len, low, fill, w);
            exp_pad = model_pad_bad(len, fill, w);
            do_cfg(len, msb, low, fill);
            send_frame(len, msb, w);
            @(negedge clk);
            bus_if.si_valid = 1'b0;
            exp_cnt++;
            n_checks++;
            if (bus_if.po_valid !== 1'b1 || bus_if.po_data !== exp_w || pad_err !== exp_pad ||
                frame_cnt !== 9'(exp_cnt)) begin
                n_fail++;
                $display("FAIL random%0d len=%0d msb=%b low=%b fill=%b w=%h: data=%h pad=%b cnt=%0d, required %h/%b/%0d",
                         t, len, msb, low, fill, w, bus_if.po_data, pad_err, frame_cnt, exp_w, exp_pad, exp_cnt);
            end
        end
    endtask

    task automatic test_done();
        bus_if.po_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rx_end = 1'b1;
        @(negedge clk);
        rx_end = 1'b0;
        n_checks++;
        if (rx_done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_enter: rx_done=%b, required 1", rx_done);
        end
        send_frame(0, 1'b0, 32'hFF);
        @(negedge clk);
        bus_if.si_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus_if.po_valid !== 1'b0 || frame_cnt !== 9'(exp_cnt) || rx_done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_ignore: valid=%b cnt=%0d done=%b, required 0/%0d/1",
                     bus_if.po_valid, frame_cnt, rx_done, exp_cnt);
        end
        reset = 1'b0;
        @(negedge clk);
        reset   = 1'b1;
        exp_cnt = 0;
        n_checks++;
        if (rx_done !== 1'b0 || frame_cnt !== 9'd0 || bus_if.po_data !== 16'h0 || bus_if.po_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_reset: done=%b cnt=%0d data=%h valid=%b, required all zero",
                     rx_done, frame_cnt, bus_if.po_data, bus_if.po_valid);
        end
        do_cfg(1, 1'b0, 1'b0, 1'b0);
        send_frame(1, 1'b0, 32'h0000_BEEF);
        @(negedge clk);
        bus_if.si_valid = 1'b0;
        n_checks++;
        if (bus_if.po_valid !== 1'b1 || bus_if.po_data !== 16'hBEEF || frame_cnt !== 9'd1) begin
            n_fail++;
            $display("FAIL post_reset_frame: valid=%b data=%h cnt=%0d, required 1/beef/1",
                     bus_if.po_valid, bus_if.po_data, frame_cnt);
        end
    endtask

    initial begin
`ifdef STI_RX_PAD_CHECK_EN
        pad_on = 1'b1;
`else
        pad_on = 1'b0;
`endif
        reset = 1'b1; cfg_load = 1'b0; cfg_length = 2'b00;
        cfg_msb = 1'b0; cfg_low = 1'b0; cfg_fill = 1'b0; rx_end = 1'b0;
        bus_if.si_data = 1'b0; bus_if.si_valid = 1'b0; bus_if.po_ready = 1'b0;

        test_reset();
        test_frame_err();
        test_len16_msb();
        test_len8_low();
        test_len32_pad();
        test_overrun();
        test_back_to_back();
        test_random();
        test_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sti_rx.md
# sti_rx

Serial-to-parallel receiver for the STI serial link. It consumes the `si_data`/`si_valid` bit stream produced by the STI transmitter and reassembles each frame (8/16/24/32 bits, MSB- or LSB-first, with low-byte and fill placement) into the original 16-bit parallel word. The word is delivered through a one-entry `po_valid`/`po_ready` output buffer. The block sits on the receive side of the link and feeds the downstream word sink.

## Interface
- No parameters; frame geometry is runtime-configured through the `cfg_*` ports.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `cfg_load`  in  1  latches the `cfg_*` fields; honoured in IDLE only.
- `cfg_length`  in  2  frame length N: 00=8, 01=16, 10=24, 11=32 bits.
- `cfg_msb`  in  1  1 = first received bit is W[N-1]; 0 = first received bit is W[0].
- `cfg_low`  in  1  only meaningful when length=00: byte goes to `po_data[15:8]`.
- `cfg_fill`  in  1  only meaningful when length is 10 or 11: data is left-aligned in W.
- `si_data`  in  1  serial bit, sampled when `si_valid`=1.
- `si_valid`  in  1  bit-valid qualifier; frames are contiguous runs of valid bits.
- `rx_end`  in  1  end-of-stream indication.
- `po_data`  out  16  reassembled word.
- `po_valid`  out  1  output buffer holds a word.
- `po_ready`  in  1  sink accepts the word when `po_valid`=1 and `po_ready`=1.
- `frame_err`  out  1  one-cycle pulse: frame truncated.
- `overrun`  out  1  one-cycle pulse: completed frame dropped because the buffer was full.
- `pad_err`  out  1  one-cycle pulse: nonzero pad bit in an accepted frame.
- `rx_done`  out  1  high in DONE state.
- `frame_cnt`  out  9  count of frames loaded into the output buffer; wraps 511→0.

## Operation
- Configuration registers reset to length=00, msb=0, low=0, fill=0.
- State machine:
  - IDLE: `rx_end`=1 goes to DONE. Otherwise `si_valid`=1 captures bit 0 and goes to RECV.
  - RECV: each valid bit is captured. The Nth bit completes the frame and returns to IDLE.
  - DONE: terminal until reset. `si_valid` is ignored.
- Bit placement: the k-th received bit (k=0..N-1) is written to W[N-1-k] when msb=1, or to W[k] when msb=0. The 32-bit assembly register is cleared at frame start.
- Extraction by length:
  - len 00: low=1 gives {W[7:0], 8'h00}; low=0 gives {8'h00, W[7:0]}. No pad bits.
  - len 01: W[15:0]. No pad bits.
  - len 10: fill=1 gives W[23:8], pad W[7:0]; fill=0 gives W[15:0], pad W[23:16].
  - len 11: fill=1 gives W[31:16], pad W[15:0]; fill=0 gives W[15:0], pad W[31:16].
- `si_valid`=0 in RECV before the Nth bit:
  - pulse `frame_err`, discard partial data, return to IDLE.
  - The buffer is untouched.
- Frame completion with the buffer empty, or full with `po_ready`=1 in the same cycle:
  - load the word, set `po_valid`, increment `frame_cnt`.
- Frame completion with the buffer full and `po_ready`=0: drop the new word and pulse `overrun`. `po_data` is unchanged.
- `cfg_load` in RECV or DONE is ignored.
- `rx_end` in RECV is ignored; it takes effect only in IDLE.

## Timing
- Reset values:
  - state IDLE
  - `po_data`=0, `po_valid`=0
  - `frame_err`=0, `overrun`=0, `pad_err`=0
  - `rx_done`=0, `frame_cnt`=0
- Latency: the edge that samples the last bit loads the buffer. `po_valid`=1 in the next cycle.
- `frame_err`, `overrun` and `pad_err` assert in the cycle after the causing edge, for exactly one cycle.
- Back-to-back frames: `si_valid` may stay high across frames; the bit after the Nth starts a new frame. No gap is required.
- `po_valid` stays high and `po_data` stays stable until the accepting handshake edge. `po_valid` falls on that edge unless a new frame completes on the same edge.
- Reset asserted mid-frame or with the buffer full discards everything and restores the reset values on that edge.

## Configuration
- `STI_RX_PAD_CHECK_EN` defined: pad bits are compared against 0 and `pad_err` pulses on a mismatch. The word is still delivered.
- Not defined: no pad compare logic; `pad_err` is tied to 0.

## Test plan
- len=01, msb=1; send 16'hA5C3 MSB-first -> `po_data`=16'hA5C3, `po_valid` the cycle after the 16th bit, `frame_cnt`=1.
- len=00, low=1, msb=0; send 8'h3C LSB-first -> `po_data`=16'h3C00. Repeat with low=0 -> `po_data`=16'h003C.
- len=11, fill=1, msb=1; send 32'h1234_0000 -> `po_data`=16'h1234, `pad_err`=0. Send 32'h1234_0001 -> `pad_err` pulses, but only with `STI_RX_PAD_CHECK_EN`.
- len=10, fill=1, msb=0; drop `si_valid` after 10 bits -> `frame_err` one-cycle pulse, `po_valid` stays 0, `frame_cnt` stays 0.
- `po_ready`=0; send two back-to-back len=00 frames 8'h11 and 8'h22 -> `po_data`=16'h0011 held, `overrun` pulses once. Then `po_ready`=1 -> handshake, `po_valid` falls.
- `rx_end`=1 in IDLE -> `rx_done`=1. Later valid bits produce no output; `reset`=0 returns to IDLE with all outputs at reset values.
